// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit: single-cycle add/sub/logic/compare and
// iterative one-bit-per-cycle shifts, with valid/ready on both sides.
module alu_seq_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      result_q;
  logic                 illegal_q;
  logic [XLEN-1:0]      sh_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic                 dir_right_q;

  logic [SHAMT_W-1:0]   shamt;
  logic                 accept;
  logic                 start_shift;
  logic [XLEN-1:0]      alu_val;
  logic [XLEN-1:0]      sh_next;

  assign shamt       = b[SHAMT_W-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = ((alucontrol == OP_SLL) || (alucontrol == OP_SRL)) && (shamt != '0);
  assign sh_next     = dir_right_q ? (sh_q >> 1) : (sh_q << 1);

  // Single-cycle result; shifts only land here when shamt is zero, giving a.
  always_comb begin
    // NOTE: every path assigns alu_val (default first) so no latch is inferred.
    alu_val = '0;
    case (alucontrol)
      OP_ADD:  alu_val = a + b;
      OP_SUB:  alu_val = a - b;
      OP_AND:  alu_val = a & b;
      OP_OR:   alu_val = a | b;
      OP_XOR:  alu_val = a ^ b;
      OP_SLL:  alu_val = a;
      OP_SRL:  alu_val = a;
      OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHAMT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      illegal_q   <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          illegal_q <= alucontrol[3];
          if (start_shift) begin
            sh_q        <= a;
            cnt_q       <= shamt;
            dir_right_q <= (alucontrol == OP_SRL);
          end else begin
            result_q <= alu_val;
          end
        end
        SHIFT: begin
          sh_q  <= sh_next;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) result_q <= sh_next;
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign zero    = (result_q == '0);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alucontrol;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_seq_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int s;
    s = int'(y % 32);
    case (c)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x << s;
      4'd6: return x >> s;
      4'd7: return (signed'(x) < signed'(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [31:0] y);
    if ((c == 4'd5 || c == 4'd6) && (y % 32) != 0) return int'(y % 32) + 1;
    return 1;
  endfunction

  // Runs one transaction from IDLE; lat counts edges from accept (inclusive) to out_valid.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic z, output logic ill, output int lat);
    alucontrol = c; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alucontrol = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; z = zero; ill = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alucontrol = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if ({out_valid, in_ready, busy, result, zero, illegal} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_initial: got ov=%b ir=%b busy=%b res=%h z=%b ill=%b", out_valid, in_ready, busy, result, zero, illegal);
    end
    // Start SLL shamt=20 and reset it mid-flight.
    alucontrol = 4'd5; a = 32'd1; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({busy, in_ready} !== 2'b10) begin
      errors++; $display("FAIL reset_shift_started: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if ({out_valid, in_ready, busy, result, zero, illegal} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_midshift: got ov=%b ir=%b busy=%b res=%h z=%b ill=%b", out_valid, in_ready, busy, result, zero, illegal);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL reset_no_stale: out_valid cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_arith;
    logic [31:0] r; logic z, il; int lat;
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, r, z, il, lat);
    checks++; if ({r, z, il} !== {32'd0, 1'b1, 1'b0} || lat !== 1) begin
      errors++; $display("FAIL add_wrap: res=%h z=%b ill=%b lat=%0d want 0 1 0 1", r, z, il, lat);
    end
    run_op(4'd1, 32'd5, 32'd7, r, z, il, lat);
    checks++; if ({r, z} !== {32'hFFFF_FFFE, 1'b0} || lat !== 1) begin
      errors++; $display("FAIL sub_neg: res=%h z=%b lat=%0d want fffffffe 0 1", r, z, lat);
    end
  endtask

  task automatic test_slt;
    logic [31:0] r; logic z, il; int lat;
    run_op(4'd7, 32'h8000_0000, 32'd1, r, z, il, lat);
    checks++; if (r !== 32'd1) begin
      errors++; $display("FAIL slt_neg_lt_pos: res=%h want 1", r);
    end
    run_op(4'd7, 32'd1, 32'h8000_0000, r, z, il, lat);
    checks++; if (r !== 32'd0) begin
      errors++; $display("FAIL slt_pos_lt_neg: res=%h want 0", r);
    end
    run_op(4'd7, 32'd3, 32'd3, r, z, il, lat);
    checks++; if ({r, z} !== {32'd0, 1'b1}) begin
      errors++; $display("FAIL slt_equal: res=%h z=%b want 0 1", r, z);
    end
  endtask

  task automatic test_shifts;
    logic [31:0] r; logic z, il; int lat;
    run_op(4'd5, 32'd1, 32'd31, r, z, il, lat);
    checks++; if (r !== 32'h8000_0000 || lat !== 32) begin
      errors++; $display("FAIL sll_31: res=%h lat=%0d want 80000000 32", r, lat);
    end
    run_op(4'd6, 32'h8000_0000, 32'd4, r, z, il, lat);
    checks++; if (r !== 32'h0800_0000 || lat !== 5) begin
      errors++; $display("FAIL srl_4: res=%h lat=%0d want 08000000 5", r, lat);
    end
    run_op(4'd5, 32'h1234, 32'h20, r, z, il, lat);
    checks++; if (r !== 32'h1234 || lat !== 1) begin
      errors++; $display("FAIL sll_shamt0: res=%h lat=%0d want 1234 1", r, lat);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r; logic z, il; int lat, bad;
    alucontrol = 4'd4; a = 32'hF0F0; b = 32'h0FF0; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep offering a different op; it must be ignored while stalled.
    alucontrol = 4'd0; a = 32'd1; b = 32'd1;
    bad = 0;
    repeat (10) begin
      if (!(out_valid && result == 32'hFF00 && !in_ready)) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL backpressure_hold: bad cycles=%0d want 0 (ov=%b res=%h ir=%b)", bad, out_valid, result, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'hFF00}) begin
      errors++; $display("FAIL backpressure_release: ov=%b ir=%b res=%h want 0 1 ff00", out_valid, in_ready, result);
    end
    run_op(4'd3, 32'd3, 32'd4, r, z, il, lat);
    checks++; if (r !== 32'd7 || lat !== 1) begin
      errors++; $display("FAIL back_to_back: res=%h lat=%0d want 7 1", r, lat);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] r; logic z, il; int lat;
    run_op(4'b1010, 32'd3, 32'd4, r, z, il, lat);
    checks++; if ({r, z, il} !== {32'd0, 1'b1, 1'b1} || lat !== 1) begin
      errors++; $display("FAIL illegal_code: res=%h z=%b ill=%b lat=%0d want 0 1 1 1", r, z, il, lat);
    end
    run_op(4'd3, 32'd3, 32'd4, r, z, il, lat);
    checks++; if ({r, il} !== {32'd7, 1'b0}) begin
      errors++; $display("FAIL illegal_clears: res=%h ill=%b want 7 0", r, il);
    end
  endtask

  task automatic test_random;
    logic [31:0] r, x, y, exp; logic z, il; logic [3:0] c; int lat;
    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) y = x;
      exp = ref_result(c, x, y);
      run_op(c, x, y, r, z, il, lat);
      checks++; if (r !== exp || z !== (exp == 0) || il !== (c > 7) || lat !== ref_latency(c, y)) begin
        errors++; $display("FAIL random_%0d: code=%h a=%h b=%h res=%h z=%b ill=%b lat=%0d want %h %b %b %0d",
                           i, c, x, y, r, z, il, lat, exp, exp == 0, c > 7, ref_latency(c, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_slt();
    test_shifts();
    test_backpressure();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU decoder.
- Multi-cycle ALU with valid/ready handshakes on both the operand side and the result side.
- Add/sub/logic/compare complete in one cycle. Shifts run iteratively, one bit position per cycle.
- Serves as the execute unit for the multi-cycle core variant; the decoder's code map is authoritative.

Parameters:
- XLEN, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; shamt = b[SHAMT_W-1:0]; XLEN must equal 2**SHAMT_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and code are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- alucontrol  input  4  operation code.
- a  input  XLEN  operand A (rs1).
- b  input  XLEN  operand B (rs2 or immediate).
- out_valid  output  1  result, zero and illegal are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.
- illegal  output  1  code was outside 0000-0111.
- busy  output  1  state != IDLE.

Behaviour:
- Code map:
  - 0000 ADD: a+b, mod 2^XLEN.
  - 0001 SUB: a-b, mod 2^XLEN.
  - 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLL: a << shamt. 0110 SRL: logical a >> shamt, zero fill.
  - 0111 SLT: signed compare, result 1 if $signed(a) < $signed(b), else 0.
  - 1000-1111: result 0, illegal=1, latency as a 1-cycle op.
- States: IDLE, SHIFT, DONE.
- Reset (any state, including mid-shift): state=IDLE. Outputs: result=0, zero=1, illegal=0, out_valid=0, busy=0, in_ready=1. Any in-flight operation is discarded.
- IDLE:
  - Accept fires when in_valid && in_ready. Latch a, b, alucontrol.
  - Non-shift code, or shift with shamt==0: compute, register result, go to DONE. shamt==0 gives result=a.
  - Shift with shamt!=0: load shift register with a, load count=shamt, go to SHIFT.
- SHIFT:
  - Each cycle: shift the register by 1 in the latched direction; count -= 1.
  - When count reaches 0, result is the register value and the state goes to DONE.
  - Accept-to-out_valid latency is shamt+1 cycles, e.g. shamt=31 gives 32 cycles.
  - in_ready=0 throughout; in_valid is ignored.
- DONE:
  - out_valid=1; result, zero and illegal are held stable until the handshake.
  - On out_valid && out_ready: go to IDLE; out_valid drops the next cycle.
  - No accept in the same cycle as result hand-off, so throughput is at most 1 op per 2 cycles for 1-cycle ops.
  - out_ready=0 stalls indefinitely with no change to outputs.
- Latency for 1-cycle ops: accept at edge N, out_valid=1 after edge N (visible in cycle N+1).
- result/zero/illegal keep their last value in IDLE. They are only meaningful while out_valid=1.
- Operand inputs are sampled only at accept. Changes afterwards have no effect.
- zero is computed from the registered result, not from a combinational path.

Test Plan:
- Reset: hold reset 2 cycles mid-SHIFT (SLL, shamt=20) -> next cycle IDLE, out_valid=0, in_ready=1, busy=0, result=0, zero=1; no stale result emitted.
- Arithmetic: ADD a=0xFFFFFFFF b=1 -> result 0, zero=1, 1-cycle latency. SUB a=5 b=7 -> 0xFFFFFFFE, zero=0.
- SLT signed: a=0x80000000 b=1 -> result 1. a=1 b=0x80000000 -> result 0. a=b=3 -> result 0, zero=1.
- Shifts:
  - SLL a=1 b=31 -> 0x80000000 with out_valid exactly 32 cycles after accept.
  - SRL a=0x80000000 b=4 -> 0x08000000 after 5 cycles.
  - SLL a=0x1234 b=0x20 (shamt=0) -> 0x1234 after 1 cycle.
- Backpressure: XOR a=0xF0F0 b=0x0FF0 with out_ready=0 for 10 cycles -> out_valid held, result=0xFF00 stable, in_ready=0, and new in_valid is ignored. Raise out_ready -> IDLE next cycle, and the following op is accepted.
- Illegal: alucontrol=1010 a=3 b=4 -> result 0, illegal=1, zero=1 after 1 cycle. The next legal op (OR a=3 b=4 -> 7) returns illegal=0.
